// File: rtl/snn_inference_ctrl_pkg.sv
// Shared types and constants for the SNN inference sequencer.
// Status codes are what the host sees in the status readback register.
package snn_inference_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_RDY = 3'd1,
      S_LAUNCH   = 3'd2,
      S_GUARD    = 3'd3,
      S_RUN      = 3'd4,
      S_DRAIN    = 3'd5,
      S_DONE     = 3'd6
   } ctrl_state_t;

   localparam logic [1:0] ST_OK       = 2'b00;
   localparam logic [1:0] ST_TIMEOUT  = 2'b01;
   localparam logic [1:0] ST_ABORT    = 2'b10;
   localparam logic [1:0] ST_NOLAUNCH = 2'b11;

   localparam int DEF_TIMEOUT_CYCLES = 1000000;
   // The decoder clears its ready flag within this many cycles after NEW_IMAGE.
   localparam int GUARD_CYCLES       = 2;

endpackage

// File: rtl/snn_inference_ctrl_if.sv
// Host/encoder/decoder-facing signal bundle of the inference sequencer.
// The slave side is the controller; the master side is its environment.
interface snn_inference_ctrl_if #(
   parameter int M            = 8,
   parameter int TIMEOUT_BITS = 20
);
   logic                    start_req;
   logic                    abort;
   logic                    irq_ack;
   logic                    encoder_rdy;
   logic                    decoder_rdy;
   logic                    inference_rdy;
   logic [M-1:0]            infered_digit;
   logic                    new_image;
   logic                    busy;
   logic                    done_irq;
   logic [1:0]              status;
   logic [M-1:0]            result;
   logic [TIMEOUT_BITS-1:0] run_cycles;
   logic                    overrun;

   modport slave (
      input  start_req, abort, irq_ack, encoder_rdy, decoder_rdy,
             inference_rdy, infered_digit,
      output new_image, busy, done_irq, status, result, run_cycles, overrun
   );

   modport master (
      output start_req, abort, irq_ack, encoder_rdy, decoder_rdy,
             inference_rdy, infered_digit,
      input  new_image, busy, done_irq, status, result, run_cycles, overrun
   );
endinterface

// File: rtl/snn_inference_ctrl_sat_counter.sv
// Width-parameterised up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
   parameter int W = 20
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                q <= '0;
      else if (clr)             q <= '0;
      else if (en && (q != '1)) q <= q + W'(1);
   end

endmodule

// File: rtl/snn_inference_ctrl.sv
// Inference lifecycle sequencer: launches one image, tracks completion,
// bounds the run with a timeout and reports digit/status through an interrupt.
module snn_inference_ctrl
   import snn_inference_ctrl_pkg::*;
#(
   parameter int M              = 8,
   parameter int TIMEOUT_BITS   = 20,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                clk,
   input  logic                rstn,
   snn_inference_ctrl_if.slave bus
);

   localparam logic [TIMEOUT_BITS-1:0] TMO_LAST   = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);
   localparam logic [TIMEOUT_BITS-1:0] GUARD_LAST = TIMEOUT_BITS'(GUARD_CYCLES);

   ctrl_state_t             state, nxt;
   logic [TIMEOUT_BITS-1:0] cnt;
   logic                    both_rdy, tmo, active, cnt_clr, cap_en, fin;
   logic [1:0]              fin_st;
   logic [M-1:0]            hold, result_q;
   logic [1:0]              status_q;
   logic [TIMEOUT_BITS-1:0] run_cycles_q;
   logic                    overrun_q;

   assign both_rdy = bus.encoder_rdy & bus.decoder_rdy;
   assign tmo      = (cnt == TMO_LAST);
   assign active   = state inside {S_WAIT_RDY, S_LAUNCH, S_GUARD, S_RUN, S_DRAIN};

   // Counter restarts at WAIT_RDY entry and again so that the launch cycle reads 0.
   assign cnt_clr  = (state == S_IDLE) || (state == S_DONE) ||
                     ((state == S_WAIT_RDY) && (nxt == S_LAUNCH));
   assign fin      = (state != S_DONE) && (nxt == S_DONE);

   sat_counter #(.W(TIMEOUT_BITS)) u_cnt (
      .clk  (clk),
      .rstn (rstn),
      .clr  (cnt_clr),
      .en   (active),
      .q    (cnt)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= nxt;
   end

   // Priority: abort, then forward progress, then timeout.
   always_comb begin
      nxt    = state;
      fin_st = ST_OK;
      cap_en = 1'b0;
      if (active && bus.abort) begin
         nxt    = S_DONE;
         fin_st = ST_ABORT;
      end else begin
         case (state)
            S_IDLE:     if (bus.start_req) nxt = S_WAIT_RDY;
            S_WAIT_RDY: begin
               if (both_rdy) nxt = S_LAUNCH;
               else if (tmo) begin nxt = S_DONE; fin_st = ST_NOLAUNCH; end
            end
            S_LAUNCH: begin
               if (tmo) begin nxt = S_DONE; fin_st = ST_TIMEOUT; end
               else nxt = S_GUARD;
            end
            S_GUARD: begin
               if (tmo) begin nxt = S_DONE; fin_st = ST_TIMEOUT; end
               else if (cnt == GUARD_LAST) nxt = S_RUN;
            end
            S_RUN: begin
               if (bus.inference_rdy) begin nxt = S_DRAIN; cap_en = 1'b1; end
               else if (tmo) begin nxt = S_DONE; fin_st = ST_TIMEOUT; end
            end
            S_DRAIN: begin
               if (both_rdy) nxt = S_DONE;
               else if (tmo) begin nxt = S_DONE; fin_st = ST_TIMEOUT; end
            end
            S_DONE:     if (bus.irq_ack) nxt = S_IDLE;
            default:    nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.new_image = (state == S_LAUNCH);
      bus.busy      = active;
      bus.done_irq  = (state == S_DONE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hold         <= '0;
         result_q     <= '0;
         status_q     <= ST_OK;
         run_cycles_q <= '0;
         overrun_q    <= 1'b0;
      end else begin
         if (cap_en) hold <= bus.infered_digit;
         if (fin) begin
            status_q <= fin_st;
            result_q <= (fin_st == ST_OK) ? hold : '1;
            if (fin_st == ST_OK) run_cycles_q <= cnt;
         end
         // A start arriving with the acknowledge is dropped but still flagged.
         if ((state == S_DONE) && bus.irq_ack)      overrun_q <= bus.start_req;
         else if (bus.start_req && (state != S_IDLE)) overrun_q <= 1'b1;
      end
   end

   assign bus.result     = result_q;
   assign bus.status     = status_q;
   assign bus.run_cycles = run_cycles_q;
   assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// Directed bench for snn_inference_ctrl with a timestamp-based reference model
// compared every cycle, plus literal expectations for the documented scenarios.
module tb_snn_inference_ctrl;

   localparam int TC = 100;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   cyc = 0, checks = 0, errs = 0, ni_cnt = 0;

   snn_inference_ctrl_if #(.M(8), .TIMEOUT_BITS(20)) bus();

   snn_inference_ctrl #(.M(8), .TIMEOUT_BITS(20), .TIMEOUT_CYCLES(TC)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (bus.new_image) ni_cnt <= ni_cnt + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   // Reference model: a run is described by the cycle it entered waiting (mW),
   // the launch cycle (mL) and the capture cycle (mC); -1 means not yet.
   int         mcyc = 0, mW = 0, mL = -1, mC = -1, m_rc = 0;
   logic [7:0] mhold = 8'h00, m_res = 8'h00;
   logic [1:0] m_st = 2'b00;
   bit         m_busy = 1'b0, m_irq = 1'b0, m_ovr = 1'b0;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_busy <= 1'b0; m_irq <= 1'b0; m_ovr <= 1'b0;
         m_st <= 2'b00; m_res <= 8'h00; m_rc <= 0; mL <= -1; mC <= -1;
      end else begin : step
         int age;
         bit tmo, fin;
         logic [1:0] fst;
         age = (mL < 0) ? mcyc - mW : mcyc - mL;
         tmo = (age == TC - 1);
         fin = 1'b0;
         fst = 2'b00;
         if (m_busy) begin
            if (bus.abort) begin fin = 1'b1; fst = 2'b10; end
            else if (mL < 0) begin
               if (bus.encoder_rdy && bus.decoder_rdy) mL <= mcyc + 1;
               else if (tmo) begin fin = 1'b1; fst = 2'b11; end
            end else if (mC < 0) begin
               if ((mcyc - mL >= 3) && bus.inference_rdy) begin
                  mC <= mcyc; mhold <= bus.infered_digit;
               end else if (tmo) begin fin = 1'b1; fst = 2'b01; end
            end else begin
               if (bus.encoder_rdy && bus.decoder_rdy) begin fin = 1'b1; m_rc <= mcyc - mL; end
               else if (tmo) begin fin = 1'b1; fst = 2'b01; end
            end
            if (fin) begin
               m_busy <= 1'b0; m_irq <= 1'b1; m_st <= fst;
               m_res  <= (fst == 2'b00) ? mhold : 8'hFF;
            end
            if (bus.start_req) m_ovr <= 1'b1;
         end else if (m_irq) begin
            if (bus.irq_ack) begin m_irq <= 1'b0; m_ovr <= bus.start_req; end
            else if (bus.start_req) m_ovr <= 1'b1;
         end else if (bus.start_req) begin
            m_busy <= 1'b1; mW <= mcyc + 1; mL <= -1; mC <= -1;
         end
         mcyc <= mcyc + 1;
      end
   end

   always @(negedge clk) begin
      chk("model new_image",  bus.new_image,  m_busy && (mL == mcyc));
      chk("model busy",       bus.busy,       m_busy);
      chk("model done_irq",   bus.done_irq,   m_irq);
      chk("model status",     bus.status,     m_st);
      chk("model result",     bus.result,     m_res);
      chk("model run_cycles", bus.run_cycles, m_rc);
      chk("model overrun",    bus.overrun,    m_ovr);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_run(output int w);
      bus.start_req = 1'b1;
      tick(1);
      bus.start_req = 1'b0;
      w = cyc;
   endtask

   task automatic ack();
      bus.irq_ack = 1'b1;
      tick(1);
      bus.irq_ack = 1'b0;
   endtask

   task automatic wait_irq(input int lim, output int at);
      at = -1;
      for (int i = 0; i < lim; i++) begin
         if (bus.done_irq) begin at = cyc; break; end
         tick(1);
      end
      if (at < 0) begin
         checks++; errs++;
         $display("FAIL irq_wait: got no done_irq expected one within %0d cycles", lim);
      end
   endtask

   initial begin
      int w, l, t, n0;
      bus.start_req = 1'b0; bus.abort = 1'b0; bus.irq_ack = 1'b0;
      bus.encoder_rdy = 1'b1; bus.decoder_rdy = 1'b1;
      bus.inference_rdy = 1'b0; bus.infered_digit = 8'h00;
      tick(2);
      chk("reset busy", bus.busy, 0);
      chk("reset status", bus.status, 0);
      chk("reset result", bus.result, 0);
      rstn = 1'b1;
      tick(2);

      // Normal run: digit 7 at launch+40, ready flags back at launch+45.
      n0 = ni_cnt;
      start_run(w);
      chk("busy after start", bus.busy, 1);
      tick(1); l = cyc;
      chk("new_image at t+2", bus.new_image, 1);
      bus.encoder_rdy = 1'b0; bus.decoder_rdy = 1'b0;
      tick(40); bus.inference_rdy = 1'b1; bus.infered_digit = 8'd7;
      tick(1);  bus.inference_rdy = 1'b0; bus.infered_digit = 8'd0;
      tick(4);  bus.encoder_rdy = 1'b1; bus.decoder_rdy = 1'b1;
      tick(1);
      chk("normal done_irq", bus.done_irq, 1);
      chk("normal result", bus.result, 7);
      chk("normal status", bus.status, 0);
      chk("normal run_cycles", bus.run_cycles, 45);
      chk("normal one new_image", ni_cnt - n0, 1);
      ack();
      chk("ack done_irq low", bus.done_irq, 0);
      chk("ack busy low", bus.busy, 0);

      // Abort while idle is ignored.
      bus.abort = 1'b1; tick(1); bus.abort = 1'b0;
      chk("idle abort busy", bus.busy, 0);
      chk("idle abort irq", bus.done_irq, 0);

      // Guard window: stale ready flag through launch and guard is ignored.
      start_run(w);
      bus.inference_rdy = 1'b1; bus.infered_digit = 8'h09;
      tick(1);
      tick(3);  bus.inference_rdy = 1'b0;
      tick(10); bus.inference_rdy = 1'b1; bus.infered_digit = 8'd3;
      tick(1);  bus.inference_rdy = 1'b0;
      tick(1);
      chk("guard result", bus.result, 3);
      chk("guard run_cycles", bus.run_cycles, 14);
      ack();

      // Timeout after launch: counter restarts at NEW_IMAGE.
      start_run(w);
      tick(1); l = cyc;
      wait_irq(200, t);
      chk("timeout irq cycle", t - l, 100);
      chk("timeout status", bus.status, 1);
      chk("timeout result", bus.result, 8'hFF);
      ack();

      // Decoder never ready: no launch, status 11.
      bus.decoder_rdy = 1'b0;
      n0 = ni_cnt;
      start_run(w);
      wait_irq(200, t);
      chk("nolaunch irq cycle", t - w, 100);
      chk("nolaunch status", bus.status, 3);
      chk("nolaunch result", bus.result, 8'hFF);
      chk("nolaunch no new_image", ni_cnt - n0, 0);
      ack();
      bus.decoder_rdy = 1'b1;

      // Abort coincident with inference_rdy in RUN.
      start_run(w);
      tick(6);
      bus.abort = 1'b1; bus.inference_rdy = 1'b1; bus.infered_digit = 8'd5;
      tick(1);
      bus.abort = 1'b0; bus.inference_rdy = 1'b0;
      chk("abort done_irq", bus.done_irq, 1);
      chk("abort status", bus.status, 2);
      chk("abort result", bus.result, 8'hFF);
      ack();

      // Overrun: extra start in RUN, then start together with the acknowledge.
      n0 = ni_cnt;
      start_run(w);
      tick(6);
      bus.start_req = 1'b1; tick(1); bus.start_req = 1'b0;
      chk("overrun set in run", bus.overrun, 1);
      tick(4); bus.inference_rdy = 1'b1; bus.infered_digit = 8'd4;
      tick(1); bus.inference_rdy = 1'b0;
      tick(1);
      chk("overrun run result", bus.result, 4);
      bus.start_req = 1'b1; bus.irq_ack = 1'b1;
      tick(1);
      bus.start_req = 1'b0; bus.irq_ack = 1'b0;
      chk("overrun kept on start+ack", bus.overrun, 1);
      chk("start+ack dropped", bus.busy, 0);
      tick(5);
      chk("overrun single run", ni_cnt - n0, 1);
      start_run(w);
      tick(5); bus.inference_rdy = 1'b1; bus.infered_digit = 8'd6;
      tick(1); bus.inference_rdy = 1'b0;
      tick(1);
      chk("reissued run result", bus.result, 6);
      ack();
      chk("ack clears overrun", bus.overrun, 0);

      // Reset in RUN: outputs clear immediately, no launch on release.
      start_run(w);
      tick(6);
      rstn = 1'b0;
      #1;
      chk("async reset busy", bus.busy, 0);
      chk("async reset result", bus.result, 0);
      chk("async reset run_cycles", bus.run_cycles, 0);
      n0 = ni_cnt;
      tick(1);
      rstn = 1'b1;
      tick(3);
      chk("no new_image on release", ni_cnt - n0, 0);
      start_run(w);
      tick(6); bus.inference_rdy = 1'b1; bus.infered_digit = 8'd2;
      tick(1); bus.inference_rdy = 1'b0;
      tick(1);
      chk("post-reset result", bus.result, 2);
      chk("post-reset run_cycles", bus.run_cycles, 6);
      ack();
      tick(2);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
